// File: rtl/mcu_sequencer_p.sv
// Instruction sequencer: fetches 16-bit words over a ROM req/ack and dispatches them to ALU, RAM, port and branch logic.
// Requests are held stable until acked; ALU ops take ALU_LAT wait cycles; HALT is left only through rst.
module mcu_sequencer_p #(
  parameter int DW          = 16,
  parameter int PCW         = 8,
  parameter int RAW         = 8,
  parameter int ALU_LAT     = 3,
  parameter int STACK_DEPTH = 4,
  parameter int HALT_PC     = 128
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_req,
  output logic [PCW-1:0]  rom_addr,
  input  logic            rom_ack,
  input  logic [15:0]     rom_data,
  output logic            ram_req,
  output logic            ram_we,
  output logic [RAW-1:0]  ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic            ram_ack,
  input  logic [DW-1:0]   ram_rdata,
  output logic [3:0]      alu_func,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  input  logic [2*DW-1:0] alu_result,
  input  logic [DW-1:0]   port_in,
  output logic [DW-1:0]   port_out,
  output logic [15:0]     instr_out,
  output logic            halted,
  output logic            fault
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int CW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_ALU_WAIT, S_MEM_WAIT, S_HALT} state_t;

  state_t           r_state, w_state_nxt;
  logic [PCW-1:0]   r_pc;
  logic [DW-1:0]    r_ar, r_br, r_hacc, r_port_out, r_ram_wdata;
  logic [15:0]      r_ir;
  logic [SPW-1:0]   r_sp;
  logic [PCW-1:0]   r_stack [STACK_DEPTH];
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_alu_func;
  logic             r_ram_we, r_fault;
  logic [RAW-1:0]   r_ram_addr;

  logic [2:0]       w_cls;
  logic [3:0]       w_func;
  logic [7:0]       w_imm;
  logic [DW-1:0]    w_imm_dw;
  logic [PCW-1:0]   w_pc_inc, w_target, w_top;
  logic             w_at_halt, w_full, w_empty, w_illegal, w_jump;

  assign w_cls     = r_ir[15:13];
  assign w_func    = r_ir[11:8];
  assign w_imm     = r_ir[7:0];
  assign w_imm_dw  = DW'({{DW{1'b0}}, w_imm});
  assign w_target  = PCW'({{PCW{1'b0}}, w_imm});
  assign w_pc_inc  = r_pc + PCW'(1);
  assign w_at_halt = (32'(r_pc) >= 32'(HALT_PC));
  assign w_full    = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty   = (r_sp == '0);

  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (r_sp == SPW'(i + 1)) w_top = r_stack[i];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_illegal   = 1'b0;
    w_jump      = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_at_halt)    w_state_nxt = S_HALT;
        else if (rom_ack) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        case (w_cls)
          3'b000: w_state_nxt = S_ALU_WAIT;
          3'b001: begin
            if (w_func <= 4'd1)      w_state_nxt = S_MEM_WAIT;
            else if (w_func > 4'd7)  w_illegal   = 1'b1;
          end
          3'b010: begin
            case (w_func)
              4'd0:    w_jump = (r_ar == '0);
              4'd1:    w_jump = (r_ar == r_br);
              4'd2:    w_jump = (r_br != '0);
              4'd3:    w_jump = 1'b1;
              default: w_illegal = 1'b1;
            endcase
          end
          3'b011:  w_illegal = (w_func > 4'd1);
          3'b100: begin
            case (w_func)
              4'd0:    begin w_illegal = w_full; w_jump = 1'b1; end
              4'd1:    w_illegal = w_empty;
              default: w_illegal = 1'b1;
            endcase
          end
          default: w_illegal = 1'b1;
        endcase
        if (w_illegal) w_state_nxt = S_HALT;
      end
      S_ALU_WAIT: if (r_cnt == '0) w_state_nxt = S_FETCH;
      S_MEM_WAIT: if (ram_ack)     w_state_nxt = S_FETCH;
      S_HALT:     w_state_nxt = S_HALT;
      default:    w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_ar        <= '0;
      r_br        <= '0;
      r_hacc      <= '0;
      r_ir        <= '0;
      r_sp        <= '0;
      r_cnt       <= '0;
      r_alu_func  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_port_out  <= '0;
      r_fault     <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (!w_at_halt && rom_ack) r_ir <= rom_data;
        S_EXEC: begin
          if (w_illegal) begin
            r_fault <= 1'b1;
          end else begin
            case (w_cls)
              3'b000: begin
                r_alu_func <= (w_func >= 4'd1 && w_func <= 4'd9) ? w_func : 4'd0;
                r_cnt      <= CW'(ALU_LAT - 1);
              end
              3'b001: begin
                case (w_func)
                  4'd0, 4'd1: begin
                    r_ram_we    <= w_func[0];
                    r_ram_addr  <= RAW'({{RAW{1'b0}}, w_imm});
                    r_ram_wdata <= r_ar;
                  end
                  4'd2:    r_ar <= r_br;
                  4'd3:    r_br <= r_ar;
                  4'd4:    r_ar <= w_imm_dw;
                  4'd5:    r_br <= w_imm_dw;
                  4'd6:    r_ar <= {r_ar[DW-9:0], w_imm};
                  default: r_ar <= r_hacc;
                endcase
                if (w_func > 4'd1) r_pc <= w_pc_inc;
              end
              3'b010: begin
                if (w_func == 4'd2) r_br <= r_br - DW'(1);
                r_pc <= w_jump ? w_target : w_pc_inc;
              end
              3'b011: begin
                if (w_func == 4'd0) r_ar <= port_in;
                else                r_port_out <= r_ar;
                r_pc <= w_pc_inc;
              end
              default: begin
                // Only the stack class gets here; every other class was flagged illegal.
                if (w_func == 4'd0) begin
                  for (int i = 0; i < STACK_DEPTH; i++)
                    if (r_sp == SPW'(i)) r_stack[i] <= w_pc_inc;
                  r_sp <= r_sp + SPW'(1);
                  r_pc <= w_target;
                end else begin
                  r_sp <= r_sp - SPW'(1);
                  r_pc <= w_top;
                end
              end
            endcase
          end
        end
        S_ALU_WAIT: begin
          if (r_cnt == '0) begin
            r_ar   <= alu_result[DW-1:0];
            r_hacc <= alu_result[2*DW-1:DW];
            r_pc   <= w_pc_inc;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_MEM_WAIT: begin
          if (ram_ack) begin
            if (!r_ram_we) r_ar <= ram_rdata;
            r_ram_we <= 1'b0;
            r_pc     <= w_pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // rst gates the fetch request so nothing is asserted while reset is held.
  assign rom_req   = (r_state == S_FETCH) && !w_at_halt && !rst;
  assign rom_addr  = r_pc;
  assign ram_req   = (r_state == S_MEM_WAIT);
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign alu_func  = r_alu_func;
  assign alu_a     = r_ar;
  assign alu_b     = r_br;
  assign port_out  = r_port_out;
  assign instr_out = r_ir;
  assign halted    = (r_state == S_HALT);
  assign fault     = r_fault;
endmodule
